// File: rtl/bmc_soft_pipe.sv
// Registered soft-decision branch-metric computer: per symbol, distance of all 2^N
// candidate codewords with periodic puncturing and per-bit erasure, one output register.
module bmc_soft_pipe #(
    parameter int                        N            = 2,
    parameter int                        SOFT_W       = 3,
    parameter int                        PUNCT_PERIOD = 1,
    parameter logic [N*PUNCT_PERIOD-1:0] PUNCT_PAT    = '1,
    localparam int                       MET_W        = $clog2(N*(2**SOFT_W-1)+1),
    localparam int                       PH_W         = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [N*SOFT_W-1:0]     in_sym,
    input  logic [N-1:0]            in_erase,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic [PH_W-1:0]         out_phase,
    output logic [(2**N)*MET_W-1:0] out_metrics
);

    localparam int                NH   = 2**N;
    localparam logic [SOFT_W-1:0] SMAX = '1;

    logic                  accept;
    logic [PH_W-1:0]       phase_q, phase_d, eff_ph;
    logic [PH_W:0]         ph_inc;
    logic [N-1:0]          pat_row, keep;
    logic [NH*MET_W-1:0]   metric_now;

    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic [PH_W-1:0]       out_phase_q, out_phase_d;
    logic [NH*MET_W-1:0]   out_metrics_q, out_metrics_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame symbol always uses phase 0, regardless of the counter.
    always_comb begin
        eff_ph  = in_sof ? '0 : phase_q;
        pat_row = '0;
        for (int p = 0; p < PUNCT_PERIOD; p++) begin
            if (eff_ph == PH_W'(p)) pat_row = PUNCT_PAT[p*N +: N];
        end
        keep   = pat_row & ~in_erase;
        ph_inc = {1'b0, eff_ph} + (PH_W+1)'(1);
    end

    for (genvar gi = 0; gi < NH; gi++) begin : g_hyp
        localparam logic [N-1:0] HYP = N'(gi);
        logic [MET_W-1:0] sum;

        always_comb begin
            sum = '0;
            for (int j = 0; j < N; j++) begin
                if (keep[j]) begin
                    sum = sum + MET_W'(HYP[j] ? (SMAX - in_sym[j*SOFT_W +: SOFT_W])
                                              : in_sym[j*SOFT_W +: SOFT_W]);
                end
            end
        end

        assign metric_now[gi*MET_W +: MET_W] = sum;
    end

    always_comb begin
        phase_d       = phase_q;
        out_valid_d   = out_valid_q;
        out_sof_d     = out_sof_q;
        out_phase_d   = out_phase_q;
        out_metrics_d = out_metrics_q;
        if (accept) begin
            phase_d       = (ph_inc == (PH_W+1)'(PUNCT_PERIOD)) ? '0 : ph_inc[PH_W-1:0];
            out_valid_d   = 1'b1;
            out_sof_d     = in_sof;
            out_phase_d   = eff_ph;
            out_metrics_d = metric_now;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_phase_q   <= '0;
            out_metrics_q <= '0;
        end else begin
            phase_q       <= phase_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_phase_q   <= out_phase_d;
            out_metrics_q <= out_metrics_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_phase   = out_phase_q;
    assign out_metrics = out_metrics_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: punctured soft-decision instance against a transaction-level
// reference model, plus a hard-decision instance for the degenerate configuration.
module tb_bmc_soft_pipe;

    localparam int N      = 2;
    localparam int SW     = 3;
    localparam int PERIOD = 2;
    localparam int PAT    = 7;   // 4'b0111
    localparam int MW     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, in_sof = 1'b0;
    logic [5:0]  in_sym = '0;
    logic [1:0]  in_erase = '0;
    logic        out_valid, out_ready = 1'b1, out_sof;
    logic [0:0]  out_phase;
    logic [15:0] out_metrics;

    logic        h_in_valid = 1'b0, h_in_ready, h_in_sof = 1'b0;
    logic [1:0]  h_in_sym = '0, h_in_erase = '0;
    logic        h_out_valid, h_out_ready = 1'b1, h_out_sof;
    logic [0:0]  h_out_phase;
    logic [7:0]  h_out_metrics;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model state: what the output register should present.
    logic        m_valid = 1'b0;
    logic        m_sof = 1'b0;
    int          m_phase = 0;
    int          m_ph = 0;
    logic [63:0] m_metrics = '0;
    logic        last_acc = 1'b0;
    int          n_deliv = 0;

    always #5 clk = ~clk;

    bmc_soft_pipe #(.N(N), .SOFT_W(SW), .PUNCT_PERIOD(PERIOD), .PUNCT_PAT(4'b0111)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_sym(in_sym), .in_erase(in_erase),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_phase(out_phase), .out_metrics(out_metrics)
    );

    bmc_soft_pipe #(.N(2), .SOFT_W(1)) u_hard (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_sof(h_in_sof),
        .in_sym(h_in_sym), .in_erase(h_in_erase),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sof(h_out_sof),
        .out_phase(h_out_phase), .out_metrics(h_out_metrics)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Distance of every hypothesis, straight from the cost rules.
    function automatic logic [63:0] ref_metrics(int n, int sw, int mw, int sym, int erase, int kept);
        logic [63:0] res;
        int smax, s, r;
        res  = '0;
        smax = (1 << sw) - 1;
        for (int h = 0; h < (1 << n); h++) begin
            s = 0;
            for (int j = 0; j < n; j++) begin
                if (((kept >> j) & 1) == 1 && ((erase >> j) & 1) == 0) begin
                    r = (sym >> (j*sw)) & smax;
                    s += (((h >> j) & 1) == 1) ? (smax - r) : r;
                end
            end
            res |= 64'(s) << (h*mw);
        end
        return res;
    endfunction

    // One clock: check outputs at negedge, advance the model on a handshake.
    task automatic tick();
        int eff;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        if (m_valid) begin
            chk("out_metrics", 64'(out_metrics), m_metrics);
            chk("out_phase", 64'(out_phase), 64'(m_phase));
            chk("out_sof", 64'(out_sof), 64'(m_sof));
            if (out_ready) n_deliv++;
        end
        last_acc = in_valid && (!m_valid || out_ready);
        if (last_acc) begin
            eff       = in_sof ? 0 : m_ph;
            m_metrics = ref_metrics(N, SW, MW, int'(in_sym), int'(in_erase), (PAT >> (eff*N)) & 3);
            m_phase   = eff;
            m_sof     = in_sof;
            m_valid   = 1'b1;
            m_ph      = (eff + 1) % PERIOD;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] syms [5];
        int d0, sent, c;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_metrics", 64'(out_metrics), 64'd0);
        chk("rst_out_phase", 64'(out_phase), 64'd0);
        chk("rst_out_sof", 64'(out_sof), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Soft decision: bit0=7, bit1=0
        in_valid = 1'b1; in_sof = 1'b1; in_sym = {3'd0, 3'd7}; out_ready = 1'b1;
        tick();
        chk("soft_const", 64'(out_metrics), 64'h7E07);
        chk("soft_phase", 64'(out_phase), 64'd0);

        // Puncturing: phases 0,1,0 then a mid-stream sof
        in_sym = 6'h3F;
        tick();
        chk("punct_p0_metrics", 64'(out_metrics), 64'h077E);
        chk("punct_p0_phase", 64'(out_phase), 64'd0);
        in_sof = 1'b0;
        tick();
        chk("punct_p1_metrics", 64'(out_metrics), 64'h0707);
        chk("punct_p1_phase", 64'(out_phase), 64'd1);
        tick();
        chk("punct_p0b_metrics", 64'(out_metrics), 64'h077E);
        chk("punct_p0b_phase", 64'(out_phase), 64'd0);
        tick();
        chk("punct_p1b_phase", 64'(out_phase), 64'd1);
        in_sof = 1'b1;
        tick();
        chk("punct_sof_restart", 64'(out_phase), 64'd0);
        in_sof = 1'b0; in_valid = 1'b0;
        tick();

        // Backpressure: 5 symbols, out_ready low on cycles 2-4
        foreach (syms[i]) syms[i] = 6'($urandom);
        d0 = n_deliv; sent = 0; c = 0;
        while ((sent < 5 || m_valid) && c < 40) begin
            c++;
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 5);
            in_sym    = syms[sent < 5 ? sent : 4];
            in_erase  = '0;
            tick();
            if (last_acc) sent++;
        end
        chk("bp_accepted", 64'(sent), 64'd5);
        chk("bp_delivered", 64'(n_deliv - d0), 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Full throughput: 16 back-to-back symbols
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sof   = (i == 0);
            in_sym   = 6'($urandom);
            in_erase = 2'($urandom);
            tick();
            if (i > 0) chk("tput_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_sof    = ($urandom_range(0, 7) == 0);
            in_sym    = 6'($urandom);
            in_erase  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            tick();
        end

        // Reset mid-stream with a held output and phase counter at 1
        in_valid = 1'b1; in_sof = 1'b1; in_sym = 6'h15; in_erase = '0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_metrics", 64'(out_metrics), 64'd0);
        chk("midrst_out_phase", 64'(out_phase), 64'd0);
        chk("midrst_out_sof", 64'(out_sof), 64'd0);
        m_valid = 1'b0; m_ph = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; in_sym = 6'h3F;
        tick();
        chk("midrst_phase0", 64'(out_phase), 64'd0);
        in_valid = 1'b0;
        tick();

        // Hard decision instance
        h_in_valid = 1'b1; h_in_sym = 2'b10; h_in_erase = 2'b00; h_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hard_valid", 64'(h_out_valid), 64'd1);
        chk("hard_const", 64'(h_out_metrics), 64'h49);
        chk("hard_model", 64'(h_out_metrics), ref_metrics(2, 1, 2, 2, 0, 3));
        h_in_erase = 2'b10;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        @(negedge clk);
        chk("hard_erase", 64'(h_out_metrics), ref_metrics(2, 1, 2, 2, 2, 3));
        chk("hard_phase", 64'(h_out_phase), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hard_drain", 64'(h_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
